// File: rtl/cache_mem_arbiter.sv
// Shared RAM port arbiter between icache (read-only) and dcache (read/write).
// Define ARB_STATS_EN to add saturating grant/stall statistic counters.
module cache_mem_arbiter #(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned BLOCK_WORDS  = 2,
    parameter int unsigned HOLD_CYCLES  = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [DATA_W-1:0] iaddr,
    output logic              iwait,
    output logic [DATA_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [DATA_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dwait,
    output logic [DATA_W-1:0] dload,
    output logic              ram_ren,
    output logic              ram_wen,
    output logic [DATA_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_store,
    input  logic [DATA_W-1:0] ram_load,
    input  logic              ram_ready
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]       stat_igrant,
    output logic [15:0]       stat_dgrant,
    output logic [15:0]       stat_istall
`endif
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(BLOCK_WORDS - 1);
    localparam logic [CNT_W-1:0] HOLD_MAX   = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        D_HOLD  = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] beat_cnt;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] starve_cnt;

    logic dreq;
    logic starve_full;
    logic d_win;
    logic i_done;
    logic d_done;
    logic d_read;

    assign dreq        = dREN | dWEN;
    assign d_read      = dREN & ~dWEN;
    assign starve_full = (starve_cnt == STARVE_MAX);
    // icache overrides dcache only once it has been starved long enough
    assign d_win       = dreq & ~(starve_full & iREN);
    assign i_done      = (state == SERVE_I) & iREN & ram_ready;
    assign d_done      = (state == SERVE_D) & dreq & ram_ready;

    // Ownership FSM with beat, hold and starvation counters
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            beat_cnt   <= '0;
            hold_cnt   <= '0;
            starve_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (d_win) begin
                        state    <= SERVE_D;
                        beat_cnt <= '0;
                    end else if (iREN) begin
                        state <= SERVE_I;
                    end
                end
                SERVE_I: begin
                    if (!iREN) begin
                        state    <= IDLE;
                        beat_cnt <= '0;
                    end else if (ram_ready) begin
                        state      <= IDLE;
                        starve_cnt <= '0;
                    end
                end
                SERVE_D: begin
                    if (!dreq) begin
                        state    <= IDLE;
                        beat_cnt <= '0;
                    end else if (ram_ready) begin
                        if (iREN && !starve_full) begin
                            starve_cnt <= starve_cnt + CNT_W'(1);
                        end
                        if (beat_cnt == LAST_BEAT) begin
                            beat_cnt <= '0;
                            state    <= IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + CNT_W'(1);
                            hold_cnt <= '0;
                            state    <= D_HOLD;
                        end
                    end
                end
                D_HOLD: begin
                    if (dreq) begin
                        state <= SERVE_D;
                    end else if (hold_cnt == HOLD_MAX) begin
                        beat_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // RAM strobes and cache handshakes follow the live request of the owner
    always_comb begin
        ram_ren   = 1'b0;
        ram_wen   = 1'b0;
        ram_addr  = '0;
        ram_store = '0;
        iwait     = 1'b1;
        dwait     = 1'b1;
        iload     = '0;
        dload     = '0;
        case (state)
            SERVE_I: begin
                if (iREN) begin
                    ram_ren  = 1'b1;
                    ram_addr = iaddr;
                end
                if (i_done) begin
                    iwait = 1'b0;
                    iload = ram_load;
                end
            end
            SERVE_D: begin
                if (dreq) begin
                    ram_ren   = d_read;
                    ram_wen   = dWEN;
                    ram_addr  = daddr;
                    ram_store = dstore;
                end
                if (d_done) begin
                    dwait = 1'b0;
                    if (d_read) begin
                        dload = ram_load;
                    end
                end
            end
            default: ;
        endcase
    end

`ifdef ARB_STATS_EN
    logic i_win;
    assign i_win = (state == IDLE) & iREN & ~d_win;

    // Saturating usage statistics
    always_ff @(posedge CLK) begin
        if (RST) begin
            stat_igrant <= '0;
            stat_dgrant <= '0;
            stat_istall <= '0;
        end else begin
            if (i_win && (stat_igrant != 16'hFFFF)) begin
                stat_igrant <= stat_igrant + 16'd1;
            end
            if (d_done && (stat_dgrant != 16'hFFFF)) begin
                stat_dgrant <= stat_dgrant + 16'd1;
            end
            if (iREN && iwait && (stat_istall != 16'hFFFF)) begin
                stat_istall <= stat_istall + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: vector table, corner sequences
// and randomized traffic against an ownership-level reference model.
module tb_cache_mem_arbiter;

    localparam int W  = 32;
    localparam int BW = 2;
    localparam int HC = 2;
    localparam int SL = 2;
    localparam int NV = 11;

    logic          CLK = 1'b0;
    logic          RST;
    logic          iREN;
    logic [W-1:0]  iaddr;
    logic          iwait;
    logic [W-1:0]  iload;
    logic          dREN;
    logic          dWEN;
    logic [W-1:0]  daddr;
    logic [W-1:0]  dstore;
    logic          dwait;
    logic [W-1:0]  dload;
    logic          ram_ren;
    logic          ram_wen;
    logic [W-1:0]  ram_addr;
    logic [W-1:0]  ram_store;
    logic [W-1:0]  ram_load;
    logic          ram_ready;
`ifdef ARB_STATS_EN
    logic [15:0]   stat_igrant;
    logic [15:0]   stat_dgrant;
    logic [15:0]   stat_istall;
`endif

    cache_mem_arbiter #(
        .DATA_W(W), .BLOCK_WORDS(BW), .HOLD_CYCLES(HC), .STARVE_LIMIT(SL)
    ) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr),
        .ram_store(ram_store), .ram_load(ram_load), .ram_ready(ram_ready)
`ifdef ARB_STATS_EN
        , .stat_igrant(stat_igrant), .stat_dgrant(stat_dgrant),
        .stat_istall(stat_istall)
`endif
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    // Reference model: who owns the port, and how far into a block/gap it is
    int m_owner;   // 0 none, 1 icache, 2 dcache
    bit m_gap;     // dcache owns the port but sits between beats
    int m_beats;
    int m_idle;
    int m_starve;

    typedef struct {
        logic rst; logic iren; logic [31:0] iaddr;
        logic dren; logic dwen; logic [31:0] daddr; logic [31:0] dstore;
        logic [31:0] rload; logic rready;
        logic e_iwait; logic [31:0] e_iload; logic e_dwait; logic [31:0] e_dload;
        logic e_ren; logic e_wen; logic [31:0] e_addr; logic [31:0] e_store;
    } vec_t;

    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit dq;
        dq = dREN || dWEN;
        if (RST) begin
            m_owner = 0; m_gap = 0; m_beats = 0; m_idle = 0; m_starve = 0;
        end else if (m_owner == 0) begin
            if (dq && !(m_starve == SL && iREN)) begin
                m_owner = 2; m_gap = 0; m_beats = 0;
            end else if (iREN) begin
                m_owner = 1;
            end
        end else if (m_owner == 1) begin
            if (!iREN) m_owner = 0;
            else if (ram_ready) begin m_owner = 0; m_starve = 0; end
        end else if (!m_gap) begin
            if (!dq) begin
                m_owner = 0; m_beats = 0;
            end else if (ram_ready) begin
                if (iREN && m_starve < SL) m_starve++;
                m_beats++;
                if (m_beats == BW) begin m_owner = 0; m_beats = 0; end
                else begin m_gap = 1; m_idle = 0; end
            end
        end else begin
            if (dq) m_gap = 0;
            else if (m_idle == HC) begin m_owner = 0; m_gap = 0; m_beats = 0; end
            else m_idle++;
        end
    endtask

    task automatic model_check();
        logic e_ren, e_wen, e_iw, e_dw;
        logic [31:0] e_addr, e_store, e_il, e_dl;
        e_ren = 0; e_wen = 0; e_iw = 1; e_dw = 1;
        e_addr = 0; e_store = 0; e_il = 0; e_dl = 0;
        if (m_owner == 1 && iREN) begin
            e_ren = 1; e_addr = iaddr;
            if (ram_ready) begin e_iw = 0; e_il = ram_load; end
        end else if (m_owner == 2 && !m_gap && (dREN || dWEN)) begin
            e_wen = dWEN; e_ren = dREN && !dWEN; e_addr = daddr; e_store = dstore;
            if (ram_ready) begin
                e_dw = 0;
                if (dREN && !dWEN) e_dl = ram_load;
            end
        end
        chk("m_iwait", 32'(iwait), 32'(e_iw));
        chk("m_iload", iload, e_il);
        chk("m_dwait", 32'(dwait), 32'(e_dw));
        chk("m_dload", dload, e_dl);
        chk("m_ren", 32'(ram_ren), 32'(e_ren));
        chk("m_wen", 32'(ram_wen), 32'(e_wen));
        chk("m_addr", ram_addr, e_addr);
        chk("m_store", ram_store, e_store);
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step();
        @(negedge CLK);
    endtask

    task automatic clr();
        RST = 0; iREN = 0; iaddr = 0; dREN = 0; dWEN = 0;
        daddr = 0; dstore = 0; ram_load = 0; ram_ready = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] log_q [$];
        logic [31:0] e_log [5];
        int b_q [$];
        int e_b [6];
        int dcnt;
        bit found;

        m_owner = 0; m_gap = 0; m_beats = 0; m_idle = 0; m_starve = 0;

        vecs[0]  = '{0,1,32'h40,0,0,0,0,0,0,            1,0,1,0,0,0,0,0};
        vecs[1]  = '{0,1,32'h40,0,0,0,0,0,0,            1,0,1,0,1,0,32'h40,0};
        vecs[2]  = '{0,1,32'h40,0,0,0,0,0,0,            1,0,1,0,1,0,32'h40,0};
        vecs[3]  = '{0,1,32'h40,0,0,0,0,32'hDEADBEEF,1, 0,32'hDEADBEEF,1,0,1,0,32'h40,0};
        vecs[4]  = '{0,0,0,0,0,0,0,0,0,                 1,0,1,0,0,0,0,0};
        vecs[5]  = '{0,0,0,0,1,32'h100,32'h11111111,0,0, 1,0,1,0,0,0,0,0};
        vecs[6]  = '{0,0,0,0,1,32'h100,32'h11111111,0,1, 1,0,0,0,0,1,32'h100,32'h11111111};
        vecs[7]  = '{0,0,0,0,0,0,0,0,0,                 1,0,1,0,0,0,0,0};
        vecs[8]  = '{0,0,0,1,0,32'h104,0,32'h55,1,      1,0,1,0,0,0,0,0};
        vecs[9]  = '{0,0,0,1,0,32'h104,0,32'h55,1,      1,0,0,32'h55,1,0,32'h104,0};
        vecs[10] = '{0,0,0,0,0,0,0,0,1,                 1,0,1,0,0,0,0,0};

        // Reset state
        clr(); RST = 1;
        tick();
        #1;
        chk("rst_ren", 32'(ram_ren), 0);
        chk("rst_wen", 32'(ram_wen), 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_store", ram_store, 0);
        chk("rst_iwait", 32'(iwait), 1);
        chk("rst_dwait", 32'(dwait), 1);
        chk("rst_iload", iload, 0);
        chk("rst_dload", dload, 0);
        RST = 0;

        // Vector table
        for (int i = 0; i < NV; i++) begin
            RST = vecs[i].rst; iREN = vecs[i].iren; iaddr = vecs[i].iaddr;
            dREN = vecs[i].dren; dWEN = vecs[i].dwen; daddr = vecs[i].daddr;
            dstore = vecs[i].dstore; ram_load = vecs[i].rload; ram_ready = vecs[i].rready;
            #1;
            chk($sformatf("v%0d_iwait", i), 32'(iwait), 32'(vecs[i].e_iwait));
            chk($sformatf("v%0d_iload", i), iload, vecs[i].e_iload);
            chk($sformatf("v%0d_dwait", i), 32'(dwait), 32'(vecs[i].e_dwait));
            chk($sformatf("v%0d_dload", i), dload, vecs[i].e_dload);
            chk($sformatf("v%0d_ren", i), 32'(ram_ren), 32'(vecs[i].e_ren));
            chk($sformatf("v%0d_wen", i), 32'(ram_wen), 32'(vecs[i].e_wen));
            chk($sformatf("v%0d_addr", i), ram_addr, vecs[i].e_addr);
            chk($sformatf("v%0d_store", i), ram_store, vecs[i].e_store);
            tick();
        end

        // Writeback then fill with icache pending: blocks never split
        clr();
        e_log[0] = 32'h100; e_log[1] = 32'h104; e_log[2] = 32'h80;
        e_log[3] = 32'h200; e_log[4] = 32'h204;
        dcnt = 0;
        for (int k = 0; k < 30; k++) begin
            iREN = 1; iaddr = 32'h80; ram_ready = 1; ram_load = $urandom;
            dWEN = (dcnt < 2); dREN = (dcnt >= 2 && dcnt < 4);
            daddr = (dcnt < 2) ? 32'h100 + 32'(dcnt) * 4 : 32'h200 + 32'(dcnt - 2) * 4;
            dstore = $urandom;
            #1;
            model_check();
            if (!dwait) begin log_q.push_back(daddr); dcnt++; end
            if (!iwait) log_q.push_back(iaddr);
            tick();
            if (log_q.size() >= 5) break;
        end
        for (int i = 0; i < 5; i++)
            chk($sformatf("wb_order%0d", i), (i < log_q.size()) ? log_q[i] : 32'hFFFFFFFF, e_log[i]);
        clr();
        tick();
        tick();

        // Reset in the middle of a dcache write
        clr(); dWEN = 1; daddr = 32'h300; dstore = 32'hA5A5;
        #1; model_check();
        tick();
        #1; model_check();
        chk("rst_mid_pre_wen", 32'(ram_wen), 1);
        RST = 1;
        tick();
        RST = 0; dWEN = 0; iREN = 1; iaddr = 32'h88;
        #1;
        chk("rst_mid_wen", 32'(ram_wen), 0);
        chk("rst_mid_dwait", 32'(dwait), 1);
        model_check();
        tick();
        ram_ready = 1; ram_load = 32'hCAFE0001;
        #1;
        chk("rst_first_ren", 32'(ram_ren), 1);
        chk("rst_first_addr", ram_addr, 32'h88);
        model_check();
        tick();
        clr();
        #1; model_check();
        tick();

        // Simultaneous requests: dcache block first, icache afterwards
        dcnt = 0; found = 0;
        for (int k = 0; k < 16; k++) begin
            iREN = 1; iaddr = 32'h80; dREN = (dcnt < BW); daddr = 32'h200;
            ram_ready = 1; ram_load = $urandom;
            #1;
            model_check();
            if (!dwait) dcnt++;
            if (!iwait && !found) begin
                found = 1;
                chk("both_d_before_i", 32'(dcnt), 32'(BW));
            end
            tick();
            if (found) break;
        end
        chk("both_igrant", 32'(found), 1);
        clr();
        tick();

        // Starvation: icache forced through after SL dcache beats
        e_b[0] = 2; e_b[1] = 2; e_b[2] = 1; e_b[3] = 2; e_b[4] = 2; e_b[5] = 1;
        for (int k = 0; k < 24; k++) begin
            iREN = 1; iaddr = 32'h90; dREN = 1; daddr = 32'h600;
            ram_ready = 1; ram_load = $urandom;
            #1;
            model_check();
            if (!dwait) b_q.push_back(2);
            if (!iwait) b_q.push_back(1);
            tick();
            if (b_q.size() >= 6) break;
        end
        for (int i = 0; i < 6; i++)
            chk($sformatf("starve_seq%0d", i), (i < b_q.size()) ? 32'(b_q[i]) : 32'hFFFFFFFF, 32'(e_b[i]));
        clr();
        tick();

        // Hold timeout after one beat, then pending icache granted
        iREN = 1; iaddr = 32'hA0; dREN = 1; daddr = 32'h700; ram_ready = 1;
        #1; model_check();
        tick();
        #1; model_check();
        tick();
        dREN = 0; found = 0;
        for (int k = 0; k < 10; k++) begin
            #1;
            model_check();
            if (!found && ram_ren) begin
                found = 1;
                chk("hold_delay", 32'(k), 32'(HC + 2));
                chk("hold_addr", ram_addr, 32'hA0);
            end
            tick();
            if (found) break;
        end
        chk("hold_igrant", 32'(found), 1);
        clr();
        tick();

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            RST = ($urandom_range(0, 99) == 0);
            iREN = ($urandom_range(0, 9) < 6);
            iaddr = $urandom;
            dREN = ($urandom_range(0, 9) < 4);
            dWEN = ($urandom_range(0, 9) < 3);
            daddr = $urandom;
            dstore = $urandom;
            ram_load = $urandom;
            ram_ready = 1'($urandom_range(0, 1));
            #1;
            model_check();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Arbitrates the single shared RAM port between the icache (read-only) and the dcache (read/write).
- Presents each cache with the wait/load handshake it already uses (`*wait` held high until the word completes).
- Dcache has priority and keeps ownership across the beats of a block fill or writeback, so the two cache streams are never interleaved inside a block.
- A starvation limit guarantees icache forward progress. Sits between the caches and the RAM model/bus.

Parameters:
- DATA_W, 32, data/address width in bits
- BLOCK_WORDS, 2, beats per dcache block transfer; legal 1..8
- HOLD_CYCLES, 2, idle cycles dcache ownership is kept between beats; legal 1..15
- STARVE_LIMIT, 4, consecutive dcache grants with icache pending before icache is forced to win; legal 1..15

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  reset; one clock, synchronous, active-high
- iREN  in  1  icache read request
- iaddr  in  DATA_W  icache word address
- iwait  out  1  0 for exactly the completing cycle of an icache read, else 1
- iload  out  DATA_W  icache read data, valid when iwait=0, else 0
- dREN  in  1  dcache read request
- dWEN  in  1  dcache write request
- daddr  in  DATA_W  dcache word address
- dstore  in  DATA_W  dcache write data
- dwait  out  1  0 for exactly the completing cycle of a dcache access, else 1
- dload  out  DATA_W  dcache read data, valid when dwait=0 and dREN, else 0
- ram_ren  out  1  RAM read strobe
- ram_wen  out  1  RAM write strobe
- ram_addr  out  DATA_W  RAM address
- ram_store  out  DATA_W  RAM write data
- ram_load  in  DATA_W  RAM read data, valid with ram_ready
- ram_ready  in  1  RAM completes the current access this cycle

Behaviour:
- Reset: state=IDLE, beat_cnt=0, hold_cnt=0, starve_cnt=0. Outputs: ram_ren=0, ram_wen=0, ram_addr=0, ram_store=0, iwait=1, dwait=1, iload=0, dload=0.
- Reset is sampled on every edge. Asserting RST mid-access aborts the access; RAM strobes drop the cycle after the RST edge.
- FSM states: IDLE, SERVE_I, SERVE_D, D_HOLD.
- IDLE:
  - No RAM strobes are driven.
  - Arbitration result is registered, so SERVE_x starts on the cycle after the request is first seen.
  - Dcache request (dREN|dWEN) wins, unless starve_cnt==STARVE_LIMIT and iREN=1, in which case icache wins.
  - Only iREN: go to SERVE_I.
  - No request: stay in IDLE.
- SERVE_I:
  - ram_ren=1, ram_addr=iaddr, combinationally from the live inputs.
  - On ram_ready: iwait=0, iload=ram_load, starve_cnt cleared, next state IDLE.
- SERVE_D:
  - ram_ren=dREN, ram_wen=dWEN, ram_addr=daddr, ram_store=dstore.
  - If dREN and dWEN are both high, write wins: ram_ren=0.
  - On ram_ready:
    - dwait=0; dload=ram_load if read.
    - beat_cnt increments; starve_cnt increments (saturating at STARVE_LIMIT) if iREN=1.
    - If beat_cnt+1==BLOCK_WORDS: beat_cnt wraps to 0 and next state is IDLE. Otherwise next state is D_HOLD with hold_cnt=0.
- D_HOLD:
  - No RAM strobes are driven.
  - If dREN|dWEN: go to SERVE_D next cycle, with no arbitration.
  - Otherwise hold_cnt increments. At hold_cnt==HOLD_CYCLES: beat_cnt=0, go to IDLE.
  - icache is never granted in D_HOLD.
- Request withdrawn while in SERVE_x (requesting input low): the access is aborted, strobes drop the same cycle, next state IDLE, beat_cnt=0, no completion is signalled.
- Requester stalls: while a requester's request is high and it is not completing, its wait output is 1. This includes while the other cache is being served.
- ram_ready outside SERVE_x is ignored.

Optional Feature:
- Macro ARB_STATS_EN.
- When defined, adds three outputs:
  - stat_igrant: 16-bit icache grant count
  - stat_dgrant: 16-bit dcache beat count
  - stat_istall: 16-bit count of cycles with iREN=1 and iwait=1
- All three saturate at 16'hFFFF and are cleared by RST.
- When undefined, these ports and their logic do not exist and behaviour is otherwise identical.

Test Plan:
- iREN=1, iaddr=0x40, ram_ready after 3 cycles with ram_load=0xDEADBEEF -> ram_ren/ram_addr=0x40 from cycle 1; iwait=0 and iload=0xDEADBEEF for one cycle; next state IDLE.
- iREN and dREN raised in the same cycle -> dcache served first; iwait held 1 until the dcache block completes; then icache granted.
- Dcache writeback: dWEN at 0x100/0x104, then dREN at 0x200/0x204, with iREN held high throughout -> four dcache beats with no icache grant between 0x100 and 0x104, nor between 0x200 and 0x204.
- STARVE_LIMIT=2, dREN and iREN continuously high -> after 2 dcache grants with icache pending, icache wins the next IDLE arbitration; starve_cnt returns to 0.
- After beat 1, dREN stays low for HOLD_CYCLES+1 cycles -> FSM returns to IDLE; a pending iREN is then granted; beat_cnt=0.
- RST asserted during SERVE_D with ram_ready=0 -> next cycle ram_wen=0, dwait=1, state IDLE; the first request after reset is arbitrated normally.
